// File: rtl/lc3_memaccess.sv
// lc3_memaccess: LC3 memory-access stage, one data access (direct) or pointer read + data access (indirect).
// Latency: with DMem_ready high, complete_data rises 2 edges after mem_start (direct) or 3 (indirect); +1 per wait cycle.
// Backpressure: each request is held stable until DMem_ready; after TIMEOUT_CYCLES waits it aborts with err+complete_data.

module lc3_memaccess #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_start,
  input  logic [2:0]  mem_state,
  input  logic        is_store,
  input  logic [15:0] M_Addr,
  input  logic [15:0] M_Data,
  input  logic [15:0] DMem_dout,
  input  logic        DMem_ready,
  output logic [15:0] DMem_addr,
  output logic [15:0] DMem_din,
  output logic        DMem_rd,
  output logic        DMem_we,
  output logic [15:0] memout,
  output logic        complete_data,
  output logic        busy,
  output logic        err
);

  typedef enum logic [1:0] {S_IDLE, S_ACC1, S_ACC2, S_DONE} state_t;

  // The wait counter is 8 bits wide, so only the low byte of the limit matters.
  localparam logic [7:0] TimeoutLimit = TIMEOUT_CYCLES[7:0];

  state_t      state_q;
  logic [15:0] addr_q;
  logic [15:0] din_q;
  logic [15:0] memout_q;
  logic        rd_q;
  logic        we_q;
  logic        cplt_q;
  logic        busy_q;
  logic        err_q;
  logic        store_q;
  logic        ind_q;
  logic [7:0]  wait_cnt_q;
  logic [7:0]  wait_cnt_d;
  logic        req_done;

  // The outstanding request completes on the edge where memory signals ready.
  assign req_done   = (rd_q | we_q) & DMem_ready;
  assign wait_cnt_d = wait_cnt_q + 8'd1;

  // Single FSM with registered outputs. busy stays high through the
  // complete_data cycle, so a new command is taken only in the IDLE cycle after it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      din_q      <= '0;
      memout_q   <= '0;
      rd_q       <= 1'b0;
      we_q       <= 1'b0;
      cplt_q     <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      store_q    <= 1'b0;
      ind_q      <= 1'b0;
      wait_cnt_q <= '0;
    end else begin
      cplt_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (busy_q) begin
            // Trailing cycle of the completion pulse: drop busy, ignore mem_start.
            busy_q <= 1'b0;
          end else if (mem_start) begin
            case (mem_state)
              3'd0, 3'd1: begin
                addr_q     <= M_Addr;
                din_q      <= M_Data;
                store_q    <= is_store;
                ind_q      <= mem_state[0];
                wait_cnt_q <= '0;
                busy_q     <= 1'b1;
                state_q    <= S_ACC1;
                // Indirect ops always read the pointer first, even for STI.
                we_q       <= is_store & ~mem_state[0];
                rd_q       <= ~(is_store & ~mem_state[0]);
              end
              3'd3: begin
                // No memory operation for this instruction.
              end
              default: err_q <= 1'b1;
            endcase
          end
        end
        S_ACC1, S_ACC2: begin
          if (req_done) begin
            wait_cnt_q <= '0;
            if (state_q == S_ACC1 && ind_q) begin
              // Pointer fetched: issue the data access at the pointer, as-is.
              addr_q  <= DMem_dout;
              state_q <= S_ACC2;
              we_q    <= store_q;
              rd_q    <= ~store_q;
            end else begin
              rd_q    <= 1'b0;
              we_q    <= 1'b0;
              if (!store_q) memout_q <= DMem_dout;
              state_q <= S_DONE;
            end
          end else if (wait_cnt_d == TimeoutLimit) begin
            // Memory never answered: abort but still complete so the pipeline moves on.
            rd_q       <= 1'b0;
            we_q       <= 1'b0;
            err_q      <= 1'b1;
            cplt_q     <= 1'b1;
            wait_cnt_q <= wait_cnt_d;
            state_q    <= S_IDLE;
          end else begin
            wait_cnt_q <= wait_cnt_d;
          end
        end
        S_DONE: begin
          cplt_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign DMem_addr     = addr_q;
  assign DMem_din      = din_q;
  assign DMem_rd       = rd_q;
  assign DMem_we       = we_q;
  assign memout        = memout_q;
  assign complete_data = cplt_q;
  assign busy          = busy_q;
  assign err           = err_q;

endmodule
